// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM states, Q1.7 unity constant, sample type and signed clamp helper for audio_gain_stage
package audio_pkg;

  localparam int DATA_W = 32;
  localparam int SAT_W = 128;
  localparam logic [7:0] UNITY_Q7 = 8'd128;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    MUL1,
    MUL2,
    SAT,
    WAIT_OUT,
    WRITE
  } state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W-1:0] v, input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo = ~hi;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/audio_gain_sat.sv
// audio_gain_sat: one channel of the gain multiply and Q1.7 rescale with saturation and clip detect
module audio_gain_sat
  import audio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int GAIN_W = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     mul_en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic        [GAIN_W:0]   eff_gain,
  output logic signed [DATA_W-1:0] res,
  output logic                     clip_hit
);

  localparam int P_W = DATA_W + GAIN_W + 2;

  logic signed [P_W-1:0]   prod;
  logic signed [SAT_W-1:0] scaled;
  logic signed [SAT_W-1:0] clamped;

  // full-precision product, captured once per frame in MUL2
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) prod <= '0;
    else if (mul_en) prod <= P_W'(sample) * P_W'($signed({1'b0, eff_gain}));

  // arithmetic shift drops the Q1.(GAIN_W-1) fraction, rounding toward -inf
  always_comb begin
    scaled   = SAT_W'(prod >>> (GAIN_W - 1));
    clamped  = sat_clamp(scaled, DATA_W);
    res      = DATA_W'(clamped);
    clip_hit = clamped != scaled;
  end

endmodule

// File: rtl/audio_gain_stage.sv
// audio_gain_stage: N-channel codec gain stage with mute ramp, saturation and clip flags; AUDIO_GAIN_SOFT_MUTE_EN selects soft ramp over hard mute
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 2,
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     audio_in_available,
  input  logic                     audio_out_allowed,
  output logic                     read_audio_in,
  output logic                     write_audio_out,
  input  logic [NUM_CH*DATA_W-1:0] audio_in,
  output logic [NUM_CH*DATA_W-1:0] audio_out,
  input  logic [GAIN_W-1:0]        gain,
  input  logic                     mute_req,
  output logic [NUM_CH-1:0]        clip,
  input  logic                     clip_clr,
  output logic                     busy
);

  state_t                   state;
  logic [NUM_CH*DATA_W-1:0] sample_q;
  logic [NUM_CH*DATA_W-1:0] res;
  logic [NUM_CH-1:0]        hit;
  logic [GAIN_W-1:0]        gain_q;
  logic [GAIN_W:0]          eff_gain;
  logic [7:0]               ramp;
  logic                     out_go;

  if (RAMP_STEP < 1 || RAMP_STEP > 128) begin : g_bad_ramp_step
    $error("RAMP_STEP must lie in 1..128");
  end

  assign out_go = (state == SAT || state == WAIT_OUT) && audio_out_allowed;

  // handshake FSM; read/write strobes and busy are registered with the state
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state           <= IDLE;
      read_audio_in   <= 1'b0;
      write_audio_out <= 1'b0;
      busy            <= 1'b0;
    end else begin
      read_audio_in   <= 1'b0;
      write_audio_out <= 1'b0;
      case (state)
        IDLE: if (audio_in_available) begin
          state         <= CAPTURE;
          read_audio_in <= 1'b1;
          busy          <= 1'b1;
        end
        CAPTURE: state <= MUL1;
        MUL1:    state <= MUL2;
        MUL2:    state <= SAT;
        SAT, WAIT_OUT: if (audio_out_allowed) begin
          state           <= WRITE;
          write_audio_out <= 1'b1;
        end else state <= WAIT_OUT;
        WRITE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end

`ifdef AUDIO_GAIN_SOFT_MUTE_EN
  localparam logic [8:0] STEP = 9'(RAMP_STEP);
  logic [8:0] ramp_up;
  assign ramp_up = {1'b0, ramp} + STEP;
  // mute ramp moves one step per captured frame, clamped to [0, unity]
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) ramp <= UNITY_Q7;
    else if (state == CAPTURE)
      ramp <= mute_req ? (({1'b0, ramp} > STEP) ? ramp - STEP[7:0] : 8'd0)
                       : ((ramp_up >= {1'b0, UNITY_Q7}) ? UNITY_Q7 : ramp_up[7:0]);
  // frame capture: samples and gain frozen for the frame in flight
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      sample_q <= '0;
      gain_q   <= '0;
    end else if (state == CAPTURE) begin
      sample_q <= audio_in;
      gain_q   <= gain;
    end
`else
  assign ramp = UNITY_Q7;
  // frame capture: hard mute folds into the latched gain so no ramp state exists
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      sample_q <= '0;
      gain_q   <= '0;
    end else if (state == CAPTURE) begin
      sample_q <= audio_in;
      gain_q   <= mute_req ? '0 : gain;
    end
`endif

  // effective gain = gain scaled by the Q1.7 ramp
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) eff_gain <= '0;
    else if (state == MUL1)
      eff_gain <= (GAIN_W+1)'(((GAIN_W+8)'(gain_q) * (GAIN_W+8)'(ramp)) >> 7);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    audio_gain_sat #(
      .DATA_W(DATA_W),
      .GAIN_W(GAIN_W)
    ) u_sat (
      .CLOCK_50(CLOCK_50),
      .resetn  (resetn),
      .mul_en  (state == MUL2),
      .sample  (sample_q[c*DATA_W +: DATA_W]),
      .eff_gain(eff_gain),
      .res     (res[c*DATA_W +: DATA_W]),
      .clip_hit(hit[c])
    );
  end

  // output register updates only on the edge into WRITE and holds otherwise
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) audio_out <= '0;
    else if (out_go) audio_out <= res;

  // sticky clip flags; a same-cycle clear wins over a new set
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) clip <= '0;
    else if (clip_clr) clip <= '0;
    else if (state == SAT) clip <= clip | hit;

endmodule

// File: tb/tb_audio_gain_stage.sv
// tb_audio_gain_stage: directed self-checking bench for audio_gain_stage
module tb_audio_gain_stage;

  localparam int DATA_W = 32, NUM_CH = 2, GAIN_W = 8, RAMP_STEP = 32;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic        audio_in_available = 1'b0;
  logic        audio_out_allowed = 1'b1;
  logic        read_audio_in, write_audio_out, busy;
  logic [63:0] audio_in = '0;
  logic [63:0] audio_out;
  logic [7:0]  gain = 8'h80;
  logic        mute_req = 1'b0;
  logic [1:0]  clip;
  logic        clip_clr = 1'b0;

  int checks = 0, failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  audio_gain_stage #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .GAIN_W(GAIN_W), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .audio_in_available(audio_in_available), .audio_out_allowed(audio_out_allowed),
    .read_audio_in(read_audio_in), .write_audio_out(write_audio_out),
    .audio_in(audio_in), .audio_out(audio_out),
    .gain(gain), .mute_req(mute_req),
    .clip(clip), .clip_clr(clip_clr), .busy(busy)
  );

  // stimulus only: offers one frame and records when read/write strobes appear
  task automatic do_frame(input logic [31:0] l, input logic [31:0] r, output logic [63:0] out,
                          output int rd, output int wr, output int reads);
    int cyc = 0;
    out = '0; rd = -1; wr = -1; reads = 0;
    audio_in = {r, l};
    audio_in_available = 1'b1;
    while (wr < 0 && cyc < 60) begin
      @(posedge CLOCK_50); #1; cyc++;
      if (read_audio_in) begin reads++; if (rd < 0) rd = cyc; audio_in_available = 1'b0; end
      if (write_audio_out) begin wr = cyc; out = audio_out; end
    end
    audio_in_available = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checks++; if (read_audio_in !== 1'b0) begin failures++; $display("FAIL rst_read got=%b exp=0", read_audio_in); end
    checks++; if (write_audio_out !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", write_audio_out); end
    checks++; if (audio_out !== 64'h0) begin failures++; $display("FAIL rst_audio_out got=%h exp=0", audio_out); end
    checks++; if (clip !== 2'b00) begin failures++; $display("FAIL rst_clip got=%b exp=00", clip); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    resetn = 1'b1;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_passthrough;
    logic [63:0] o; int rd, wr, n;
    gain = 8'h80; mute_req = 1'b0; audio_out_allowed = 1'b1;
    do_frame(32'h0000_1234, 32'hFFFF_FFFB, o, rd, wr, n);
    checks++; if (o !== 64'hFFFF_FFFB_0000_1234) begin failures++; $display("FAIL pass_out got=%h exp=fffffffb00001234", o); end
    checks++; if (wr - rd !== 4) begin failures++; $display("FAIL pass_latency got=%0d exp=4", wr - rd); end
    checks++; if (n !== 1) begin failures++; $display("FAIL pass_reads got=%0d exp=1", n); end
    checks++; if (clip !== 2'b00) begin failures++; $display("FAIL pass_clip got=%b exp=00", clip); end
  endtask

  task automatic test_gain;
    logic [63:0] o; int rd, wr, n;
    gain = 8'h40;
    do_frame(32'd1001, -32'sd1001, o, rd, wr, n);
    checks++; if (o[31:0] !== 32'd500) begin failures++; $display("FAIL half_gain_l got=%0d exp=500", $signed(o[31:0])); end
    checks++; if (o[63:32] !== -32'sd501) begin failures++; $display("FAIL half_gain_r got=%0d exp=-501", $signed(o[63:32])); end
    gain = 8'h80;
  endtask

  task automatic test_saturation;
    logic [63:0] o; int rd, wr, n;
    gain = 8'hFF;
    do_frame(32'h7FFF_FFFF, 32'h8000_0000, o, rd, wr, n);
    checks++; if (o !== 64'h8000_0000_7FFF_FFFF) begin failures++; $display("FAIL sat_out got=%h exp=800000007fffffff", o); end
    checks++; if (clip !== 2'b11) begin failures++; $display("FAIL sat_clip got=%b exp=11", clip); end
    clip_clr = 1'b1;
    @(posedge CLOCK_50); #1;
    clip_clr = 1'b0;
    checks++; if (clip !== 2'b00) begin failures++; $display("FAIL clip_clr got=%b exp=00", clip); end
    gain = 8'h80;
  endtask

  task automatic test_mute_ramp;
    logic [63:0] o; int rd, wr, n; logic [31:0] e;
    int exp_m[5]; int exp_u[4];
`ifdef AUDIO_GAIN_SOFT_MUTE_EN
    exp_m = '{750, 500, 250, 0, 0};
    exp_u = '{250, 500, 750, 1000};
`else
    exp_m = '{0, 0, 0, 0, 0};
    exp_u = '{1000, 1000, 1000, 1000};
`endif
    gain = 8'h80; mute_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_frame(32'd1000, 32'd1000, o, rd, wr, n);
      e = exp_m[i];
      checks++; if (o !== {e, e}) begin failures++; $display("FAIL mute_frame%0d got=%0d exp=%0d", i, $signed(o[31:0]), exp_m[i]); end
    end
    mute_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_frame(32'd1000, 32'd1000, o, rd, wr, n);
      e = exp_u[i];
      checks++; if (o !== {e, e}) begin failures++; $display("FAIL unmute_frame%0d got=%0d exp=%0d", i, $signed(o[31:0]), exp_u[i]); end
    end
  endtask

  task automatic test_backpressure;
    int got_rd = 0, nbusy = 0, nwr = 0, nrd = 0, extra = 0;
    audio_out_allowed = 1'b0;
    audio_in = {32'hFFFF_FF9C, 32'd100};
    audio_in_available = 1'b1;
    for (int i = 0; i < 20 && got_rd == 0; i++) begin
      @(posedge CLOCK_50); #1;
      if (read_audio_in) got_rd = 1;
    end
    audio_in_available = 1'b0;
    checks++; if (got_rd !== 1) begin failures++; $display("FAIL bp_read got=%0d exp=1", got_rd); end
    for (int i = 0; i < 20; i++) begin
      @(posedge CLOCK_50); #1;
      if (!busy) nbusy++;
      if (write_audio_out) nwr++;
      if (read_audio_in) nrd++;
    end
    checks++; if (nbusy !== 0) begin failures++; $display("FAIL bp_busy_drops got=%0d exp=0", nbusy); end
    checks++; if (nwr !== 0) begin failures++; $display("FAIL bp_early_write got=%0d exp=0", nwr); end
    checks++; if (nrd !== 0) begin failures++; $display("FAIL bp_second_read got=%0d exp=0", nrd); end
    audio_out_allowed = 1'b1;
    @(posedge CLOCK_50); #1;
    checks++; if (write_audio_out !== 1'b1) begin failures++; $display("FAIL bp_write got=%b exp=1", write_audio_out); end
    checks++; if (audio_out !== 64'hFFFF_FF9C_0000_0064) begin failures++; $display("FAIL bp_out got=%h exp=ffffff9c00000064", audio_out); end
    for (int i = 0; i < 5; i++) begin
      @(posedge CLOCK_50); #1;
      if (write_audio_out) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL bp_extra_write got=%0d exp=0", extra); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    int rd[2], wr[2]; int nr = 0, nw = 0, both = 0;
    audio_out_allowed = 1'b1;
    audio_in = {32'd6, 32'd5};
    audio_in_available = 1'b1;
    for (int cyc = 1; cyc <= 40 && nw < 2; cyc++) begin
      @(posedge CLOCK_50); #1;
      if (read_audio_in && write_audio_out) both++;
      if (read_audio_in) begin if (nr < 2) rd[nr] = cyc; nr++; if (nr == 2) audio_in_available = 1'b0; end
      if (write_audio_out) begin if (nw < 2) wr[nw] = cyc; nw++; end
    end
    audio_in_available = 1'b0;
    checks++; if (nr !== 2 || nw !== 2) begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", nr, nw); end
    checks++; if (nr == 2 && rd[1] - rd[0] !== 6) begin failures++; $display("FAIL b2b_read_spacing got=%0d exp=6", rd[1] - rd[0]); end
    checks++; if (nw == 2 && wr[1] - wr[0] !== 6) begin failures++; $display("FAIL b2b_write_spacing got=%0d exp=6", wr[1] - wr[0]); end
    checks++; if (both !== 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", both); end
    checks++; if (audio_out !== {32'd6, 32'd5}) begin failures++; $display("FAIL b2b_out got=%h exp=0000000600000005", audio_out); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] o; int rd, wr, n; int got_rd = 0, nwr = 0;
    audio_in = {32'd9, 32'd8};
    audio_in_available = 1'b1;
    for (int i = 0; i < 20 && got_rd == 0; i++) begin
      @(posedge CLOCK_50); #1;
      if (read_audio_in) got_rd = 1;
    end
    audio_in_available = 1'b0;
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    resetn = 1'b0;
    #1;
    checks++; if (audio_out !== 64'h0) begin failures++; $display("FAIL mid_audio_out got=%h exp=0", audio_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (write_audio_out !== 1'b0) begin failures++; $display("FAIL mid_write got=%b exp=0", write_audio_out); end
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLOCK_50); #1;
      if (write_audio_out) nwr++;
    end
    checks++; if (nwr !== 0) begin failures++; $display("FAIL mid_discard got=%0d exp=0", nwr); end
    do_frame(32'd77, -32'sd77, o, rd, wr, n);
    checks++; if (o !== {-32'sd77, 32'd77}) begin failures++; $display("FAIL mid_next_out got=%h exp=ffffffb30000004d", o); end
    checks++; if (wr - rd !== 4) begin failures++; $display("FAIL mid_next_latency got=%0d exp=4", wr - rd); end
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_gain;
    test_saturation;
    test_mute_ramp;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
